// File: rtl/up_bus_master.sv
`timescale 1ns/1ps
// up_bus_master
// Initiator for the processor-bus register interface (upen/upws/uprs/updi/
// updo/upack). It takes one read or write command at a time over a
// valid/ready port, runs a single bus access and returns the result over a
// valid/ready response port.
//
// Optional feature macro: UPMST_TIMEOUT_EN
//   Defined   : an access with no upack for TOUT_CYC cycles ends with
//               rsp_err = 1.
//   Undefined : no wait counter; ACCESS waits for upack indefinitely and
//               rsp_err is tied to 0.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cmd_vld/cmd_rdy     command handshake; cmd_wr, cmd_addr, cmd_wdat payload
//   rsp_vld/rsp_rdy     response handshake; rsp_rdat, rsp_err payload
//   upa, upen, upws,    registered bus address, enable, write/read strobes,
//   uprs, updi          write data
//   updo, upack         OR-reduced read data and acknowledge from responders
module up_bus_master #(
  parameter int CPUW     = 8,
  parameter int ADDW     = 8,
  parameter int TOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_wr,
  input  logic [ADDW-1:0] cmd_addr,
  input  logic [CPUW-1:0] cmd_wdat,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [CPUW-1:0] rsp_rdat,
  output logic            rsp_err,
  output logic [ADDW-1:0] upa,
  output logic            upen,
  output logic            upws,
  output logic            uprs,
  output logic [CPUW-1:0] updi,
  input  logic [CPUW-1:0] updo,
  input  logic            upack
);

  // Elaboration-time guard on the timeout range (the counter is 16 bits).
  generate
    if (TOUT_CYC < 1 || TOUT_CYC > 65535) begin : g_bad_tout
      $error("up_bus_master: TOUT_CYC out of range 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg;

  // Ready straight from the state so it reads 1 while reset holds IDLE.
  assign cmd_rdy = (state_reg == IDLE);

`ifdef UPMST_TIMEOUT_EN
  localparam logic [15:0] TOUT_LAST = 16'(TOUT_CYC - 1);
  logic [15:0] wait_cnt_reg;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      upa       <= '0;
      upen      <= 1'b0;
      upws      <= 1'b0;
      uprs      <= 1'b0;
      updi      <= '0;
      rsp_vld   <= 1'b0;
      rsp_rdat  <= '0;
`ifdef UPMST_TIMEOUT_EN
      rsp_err      <= 1'b0;
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // cmd_rdy is 1 in this state, so cmd_vld alone completes the handshake.
          if (cmd_vld) begin
            upa       <= cmd_addr;
            upen      <= 1'b1;
            upws      <= cmd_wr;
            uprs      <= ~cmd_wr;
            updi      <= cmd_wr ? cmd_wdat : '0;
`ifdef UPMST_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
            state_reg <= ACCESS;
          end
        end

        ACCESS: begin
          // An ack always wins, even on the edge where the timeout would fire.
          if (upack) begin
            rsp_rdat  <= uprs ? updo : '0;
            rsp_vld   <= 1'b1;
            upa       <= '0;
            upen      <= 1'b0;
            upws      <= 1'b0;
            uprs      <= 1'b0;
            updi      <= '0;
`ifdef UPMST_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state_reg <= RESP;
          end
`ifdef UPMST_TIMEOUT_EN
          else if (wait_cnt_reg == TOUT_LAST) begin
            // Abandon the access; the bus is returned fully to its idle value.
            rsp_rdat  <= '0;
            rsp_err   <= 1'b1;
            rsp_vld   <= 1'b1;
            upa       <= '0;
            upen      <= 1'b0;
            upws      <= 1'b0;
            uprs      <= 1'b0;
            updi      <= '0;
            state_reg <= RESP;
          end else if (wait_cnt_reg != 16'hFFFF) begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
`endif
        end

        RESP: begin
          if (rsp_rdy) begin
            rsp_vld   <= 1'b0;
`ifdef UPMST_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_bus_master.sv
`timescale 1ns/1ps
// Testbench for up_bus_master: a behavioural register responder with a
// programmable acknowledge delay, and a reference memory that predicts read
// data, response latency and error status for each transaction.
module tb_up_bus_master;

  localparam int CPUW = 8;
  localparam int ADDW = 8;
  localparam int TOUT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_vld = 1'b0;
  logic            cmd_rdy;
  logic            cmd_wr = 1'b0;
  logic [ADDW-1:0] cmd_addr = '0;
  logic [CPUW-1:0] cmd_wdat = '0;
  logic            rsp_vld;
  logic            rsp_rdy = 1'b0;
  logic [CPUW-1:0] rsp_rdat;
  logic            rsp_err;
  logic [ADDW-1:0] upa;
  logic            upen;
  logic            upws;
  logic            uprs;
  logic [CPUW-1:0] updi;
  logic [CPUW-1:0] updo;
  logic            upack;

  always #5 clk = ~clk;

  up_bus_master #(.CPUW(CPUW), .ADDW(ADDW), .TOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
    .upa(upa), .upen(upen), .upws(upws), .uprs(uprs), .updi(updi),
    .updo(updo), .upack(upack)
  );

  // ---------------- responder environment ----------------
  logic [7:0] seed = 8'h00;
  logic [7:0] mem [256];
  logic       present [256];
  int         ack_dly = 0;
  int         rc;

  assign upack = upen && present[upa] && (rc >= ack_dly);
  assign updo  = (upen && uprs && present[upa]) ? mem[upa] : 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst)        rc <= 0;
    else if (!upen) rc <= 0;
    else            rc <= rc + 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 29 + 90) ^ seed;
    end else if (upen && upws && upack) begin
      mem[upa] <= updi;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete command/response transaction with all protocol checks.
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdat,
                         input int dly, input int hold, input bit poke);
    bit         exp_err;
    int         exp_cyc;
    logic [7:0] exp_rdat;
    int         cyc;
`ifdef UPMST_TIMEOUT_EN
    exp_err = !present[addr] || (dly >= TOUT);
`else
    exp_err = 1'b0;
`endif
    exp_cyc  = exp_err ? TOUT : dly + 1;
    exp_rdat = (wr || exp_err) ? 8'h00 : ref_mem[addr];
    ack_dly  = dly;

    @(negedge clk);
    check_eq("cmd_rdy_idle", {31'd0, cmd_rdy}, 32'd1);
    cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdat = wdat;
    @(negedge clk);
    cmd_vld  = 1'b0;
    cmd_wdat = 8'($urandom);
    cmd_addr = 8'($urandom);

    cyc = 0;
    while (upen && cyc < 100) begin
      check_eq("upa_hold",  {24'd0, upa}, {24'd0, addr});
      check_eq("upws_hold", {31'd0, upws}, {31'd0, wr});
      check_eq("uprs_hold", {31'd0, uprs}, {31'd0, !wr});
      check_eq("updi_hold", {24'd0, updi}, wr ? {24'd0, wdat} : 32'd0);
      check_eq("cmd_rdy_busy", {31'd0, cmd_rdy}, 32'd0);
      cyc++;
      @(negedge clk);
    end
    check_eq("upen_cycles", cyc, exp_cyc);
    check_eq("rsp_vld",  {31'd0, rsp_vld}, 32'd1);
    check_eq("rsp_rdat", {24'd0, rsp_rdat}, {24'd0, exp_rdat});
    check_eq("rsp_err",  {31'd0, rsp_err}, {31'd0, exp_err});
    check_eq("strobes_idle", {30'd0, upws, uprs}, 32'd0);

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'($urandom); cmd_wdat = 8'($urandom);
      end
      @(negedge clk);
      check_eq("bp_rsp_vld",  {31'd0, rsp_vld}, 32'd1);
      check_eq("bp_rsp_rdat", {24'd0, rsp_rdat}, {24'd0, exp_rdat});
      check_eq("bp_rsp_err",  {31'd0, rsp_err}, {31'd0, exp_err});
      check_eq("bp_cmd_rdy",  {31'd0, cmd_rdy}, 32'd0);
      check_eq("bp_upen",     {31'd0, upen}, 32'd0);
    end

    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    check_eq("hs_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    check_eq("hs_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check_eq("hs_upen",    {31'd0, upen}, 32'd0);
    cmd_vld = 1'b0;

    if (wr && !exp_err) ref_mem[addr] = wdat;
    $display("txn wr=%0d addr=%02h wdat=%02h dly=%0d hold=%0d -> rdat=%02h err=%0d upen_cyc=%0d",
             wr, addr, wdat, dly, hold, rsp_rdat, exp_err, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      present[i] = 1'b1;
      ref_mem[i] = 8'(i * 29 + 90) ^ seed;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check_eq("rst_upen",    {31'd0, upen}, 32'd0);
    check_eq("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_upa",     {24'd0, upa}, 32'd0);
    check_eq("rst_updi",    {24'd0, updi}, 32'd0);
    rst = 1'b0;

    // Directed: write then read back, combinational ack
    run_txn(1'b1, 8'h12, 8'hA5, 0, 0, 1'b0);
    run_txn(1'b0, 8'h12, 8'h00, 0, 0, 1'b0);
    run_txn(1'b1, 8'h34, 8'h3C, 0, 0, 1'b0);
    run_txn(1'b0, 8'h34, 8'h00, 0, 0, 1'b0);
    // Delayed ack
    run_txn(1'b0, 8'h34, 8'h00, 4, 0, 1'b0);
    run_txn(1'b1, 8'h55, 8'h5A, 4, 0, 1'b0);
    // Response backpressure with a competing command
    run_txn(1'b0, 8'h55, 8'h00, 0, 5, 1'b1);

`ifdef UPMST_TIMEOUT_EN
    present[8'hEE] = 1'b0;
    run_txn(1'b0, 8'hEE, 8'h00, 0, 2, 1'b0);
    run_txn(1'b1, 8'hEE, 8'h77, 0, 0, 1'b0);
    run_txn(1'b0, 8'h12, 8'h00, TOUT - 1, 0, 1'b0);
    run_txn(1'b1, 8'h13, 8'h99, TOUT - 1, 0, 1'b0);
    run_txn(1'b0, 8'h13, 8'h00, 0, 0, 1'b0);
`endif

    // Reset in the middle of an access
    ack_dly = 10;
    @(negedge clk);
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h21;
    @(negedge clk);
    cmd_vld = 1'b0;
    @(negedge clk);
    check_eq("mid_upen_before", {31'd0, upen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_upen",    {31'd0, upen}, 32'd0);
    check_eq("mid_uprs",    {31'd0, uprs}, 32'd0);
    check_eq("mid_upws",    {31'd0, upws}, 32'd0);
    check_eq("mid_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    check_eq("mid_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ack_dly = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      check_eq("post_rst_upen",    {31'd0, upen}, 32'd0);
    end
    run_txn(1'b0, 8'h21, 8'h00, 1, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_bus_master.md
Name: up_bus_master

Overview:
- Initiator for the team's processor-bus register interface: the upen / upws / uprs / updi / updo / upack bus that the configuration-register macros respond to.
- Accepts single read or write commands over a valid/ready command port and drives one bus access at a time.
- Waits for upack, captures read data from updo, and returns a response over a valid/ready response port.
- Sits between a host-side bridge (UART/SPI/JTAG command decoder) and the shared register bus fan-out.

Parameters:
- CPUW, 8, data width of updi/updo and command/response data.
- ADDW, 8, address width of upa and cmd_addr.
- TOUT_CYC, 16, access timeout in cycles while waiting for upack; legal range 1..65535. Used only with UPMST_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- cmd_vld  input  1  command valid.
- cmd_rdy  output  1  command ready.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDW  register address.
- cmd_wdat  input  CPUW  write data.
- rsp_vld  output  1  response valid.
- rsp_rdy  input  1  response accepted.
- rsp_rdat  output  CPUW  read data (0 for writes and for errors).
- rsp_err  output  1  1 = access timed out.
- upa  output  ADDW  bus address.
- upen  output  1  bus enable (access in progress).
- upws  output  1  write strobe.
- uprs  output  1  read strobe.
- updi  output  CPUW  write data to responders.
- updo  input  CPUW  OR-reduced read data from responders (0 when not selected).
- upack  input  1  OR-reduced acknowledge (may be combinational from upen).

Behaviour:
- Reset (async, immediate): state IDLE; upa, upen, upws, uprs, updi, rsp_vld, rsp_rdat, rsp_err = 0; wait counter = 0. A reset mid-access aborts the access; no response is produced for it.
- All bus and response outputs are registered. cmd_rdy = (state == IDLE), combinational; it is 1 during reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On an edge with cmd_vld & cmd_rdy: load upa = cmd_addr, upen = 1, upws = cmd_wr, uprs = ~cmd_wr.
  - updi = cmd_wdat for writes, 0 for reads.
  - Clear the wait counter and go to ACCESS.
  - The bus is driven starting in the cycle after acceptance.
- ACCESS:
  - upa, updi, upen and the strobe are held stable.
  - On each edge with upack = 1:
    - rsp_rdat = updo for a read, 0 for a write; rsp_err = 0; rsp_vld = 1.
    - upen, upws, uprs, upa and updi are cleared to 0.
    - Go to RESP.
  - upack with a combinational responder therefore gives upen high for exactly 1 cycle.
  - Otherwise the wait counter increments, saturating at its maximum.
- RESP:
  - rsp_vld, rsp_rdat and rsp_err are held until an edge with rsp_rdy = 1.
  - On that edge: rsp_vld = 0, rsp_err = 0, go to IDLE.
  - The next command is accepted at the earliest one cycle later.
- Throughput: at most one transaction per 3 cycles (accept, access, response handshake).
- upack seen in IDLE or RESP is ignored.
- updo is sampled only on the acknowledge edge.
- The counter is 16 bits and saturates.

Optional Feature:
- Macro: UPMST_TIMEOUT_EN.
- When defined:
  - In ACCESS, if upack = 0 on an edge where the wait counter equals TOUT_CYC-1, the access terminates.
  - upen, upws and uprs are cleared; rsp_vld = 1, rsp_err = 1, rsp_rdat = 0; go to RESP.
  - upack = 1 on the same edge as the timeout wins: a normal response with rsp_err = 0.
- When not defined:
  - No counter logic.
  - ACCESS waits for upack indefinitely.
  - rsp_err is constant 0.

Test Plan:
- Write with combinational-ack responder:
  - Stimulus: cmd_wr = 1, cmd_addr = 0x12, cmd_wdat = 0xA5, accepted at edge T.
  - Response: upen/upws high for one cycle after T, upa = 0x12, updi = 0xA5; rsp_vld = 1 after edge T+1 with rsp_err = 0 and rsp_rdat = 0; responder register reads back 0xA5.
- Read:
  - Stimulus: responder holding 0x3C, read of the same address.
  - Response: uprs high for one cycle, updi = 0; rsp_rdat = 0x3C, rsp_err = 0.
- Delayed ack:
  - Stimulus: responder acks 4 cycles after upen rises.
  - Response: upen, uprs, upa stay stable for all 4 cycles; response follows the ack edge; counter does not fire with TOUT_CYC = 16.
- Timeout (UPMST_TIMEOUT_EN, TOUT_CYC = 16):
  - Stimulus: no responder at the address.
  - Response: upen high for exactly 16 cycles, then rsp_vld = 1, rsp_err = 1, rsp_rdat = 0.
  - Same test with the ack placed on the 16th wait cycle: rsp_err = 0.
- Response backpressure:
  - Stimulus: hold rsp_rdy = 0 for 5 cycles.
  - Response: rsp_vld and data stable; cmd_rdy = 0 throughout; a new cmd_vld is not accepted until one cycle after the rsp handshake.
- Reset mid-access:
  - Stimulus: assert rst while in ACCESS.
  - Response: upen, upws, uprs and rsp_vld drop immediately (asynchronously); cmd_rdy = 1; no rsp_vld after release; the next command completes normally.
